// File: rtl/counter_sequencer_pkg.sv
// ============================================================================
// Module      : counter_sequencer_pkg
// Description : Shared sequencer state encoding and default datapath widths.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package counter_sequencer_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_PS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_interval_counter.sv
// ============================================================================
// Module      : seq_interval_counter
// Description : Prescaled modulo counter; flags the advance that wraps to zero.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seq_interval_counter
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PS_WIDTH = DEF_PS_WIDTH
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic [WIDTH-1:0]    i_terminal,
  input  logic [PS_WIDTH-1:0] i_ps_terminal,
  output logic [WIDTH-1:0]    o_count,
  output logic                o_wrap
);

  localparam logic [WIDTH-1:0]    c_CNT_ONE = WIDTH'(1);
  localparam logic [PS_WIDTH-1:0] c_PS_ONE  = PS_WIDTH'(1);

  logic [WIDTH-1:0]    r_count;
  logic [PS_WIDTH-1:0] r_ps;
  logic [WIDTH-1:0]    w_last_value;
  logic                w_ps_hit;
  logic                w_last;

  // Terminal of 0 makes the last value all-ones, i.e. a full 2^WIDTH cycle.
  assign w_last_value = i_terminal - c_CNT_ONE;
  assign w_ps_hit     = (r_ps == i_ps_terminal);
  assign w_last       = (r_count == w_last_value);
  assign o_wrap       = i_enable && w_ps_hit && w_last;
  assign o_count      = r_count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count <= '0;
      r_ps    <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_ps    <= '0;
    end else if (i_enable) begin
      if (w_ps_hit) begin
        r_ps    <= '0;
        r_count <= w_last ? '0 : (r_count + c_CNT_ONE);
      end else begin
        r_ps <= r_ps + c_PS_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
// Module      : counter_sequencer
// Description : One-shot/periodic prescaled count sequencer with tick/done/err.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PS_WIDTH = DEF_PS_WIDTH
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                start,
  input  logic                stop,
  input  logic                periodic,
  input  logic [WIDTH-1:0]    period,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic                busy,
  output logic [WIDTH-1:0]    count,
  output logic                tick,
  output logic                done,
  output logic                err
);

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_period;
  logic [PS_WIDTH-1:0] r_prescale;
  logic                r_periodic;
  logic                r_tick;
  logic                r_done;
  logic                r_err;

  logic w_accept;
  logic w_tick;
  logic w_done;
  logic w_err;
  logic w_enable;
  logic w_clear;
  logic w_wrap;

  // Counting only continues in RUN when neither stop nor a restart is pending.
  assign w_enable = (r_state == RUN) && !stop && !start;
  assign w_clear  = !w_enable;

  seq_interval_counter #(
    .WIDTH    (WIDTH),
    .PS_WIDTH (PS_WIDTH)
  ) u_interval (
    .clk           (clk),
    .nreset        (nreset),
    .i_clear       (w_clear),
    .i_enable      (w_enable),
    .i_terminal    (r_period),
    .i_ps_terminal (r_prescale),
    .o_count       (count),
    .o_wrap        (w_wrap)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_tick   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (period != '0) begin
            w_next   = LOAD;
            w_accept = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      LOAD: w_next = stop ? IDLE : RUN;
      RUN: begin
        if (stop) begin
          w_next = IDLE;
        end else if (start) begin
          w_next   = LOAD;
          w_accept = 1'b1;
        end else if (w_wrap) begin
          w_tick = 1'b1;
          if (!r_periodic) begin
            w_next = DONE;
            w_done = 1'b1;
          end
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= IDLE;
      r_period   <= '0;
      r_prescale <= '0;
      r_periodic <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tick  <= w_tick;
      r_done  <= w_done;
      r_err   <= w_err;
      if (w_accept) begin
        r_period   <= period;
        r_prescale <= prescale;
        r_periodic <= periodic;
      end
    end
  end

  assign busy = (r_state == LOAD) || (r_state == RUN);
  assign tick = r_tick;
  assign done = r_done;
  assign err  = r_err;

endmodule

`default_nettype wire
